img_ddr_wr: RTL

//  Downstream of the image preprocessor: drains its 32-bit packed output FIFO (FWFT) into DDR via AXI4 write bursts.

---
 rtl/cmlk_ddr_pkg.sv | 17 +
 rtl/img_ddr_wr.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cmlk_ddr_pkg.sv
// Shared AXI constants and FSM state encoding for the DDR frame writer.
package cmlk_ddr_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

endpackage

// File: rtl/img_ddr_wr.sv
// Drains the preprocessor's FWFT output FIFO into one of four DDR frame slots
// using fixed-length AXI4 INCR write bursts, one burst outstanding at a time.
module img_ddr_wr
  import cmlk_ddr_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                CNT_W       = 11,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] SLOT_BYTES  = 32'h0010_0000,
  parameter int                FRAME_WORDS = 65536,
  parameter int                BURST_LEN   = 64
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              init_txn,
  input  logic [31:0]       fifo_rddata,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_rd_count,
  output logic              fifo_rden,
  input  logic              frame_store,
  input  logic [1:0]        frame_type,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        frame_done_type,
  output logic              wr_err,
  output logic              frame_overrun
);

  localparam int NBURST = FRAME_WORDS / BURST_LEN;
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int BCNT_W = $clog2(NBURST + 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);

  state_t              r_state;
  logic [1:0]          r_slot;
  logic [ADDR_W-1:0]   r_addr;
  logic [BEAT_W-1:0]   r_beat;
  logic [BCNT_W-1:0]   r_burst;
  logic [7:0]          r_awlen;
  logic                r_wrErr;
  logic                r_overrun;

  logic w_wvalid;
  logic w_wbeat;
  logic w_lastBeat;
  logic w_countOk;
  logic w_lastBurst;

  assign w_wvalid    = (r_state == ST_W) && !fifo_empty;
  assign w_wbeat     = w_wvalid && m_axi_wready;
  assign w_lastBeat  = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_countOk   = (32'(fifo_rd_count) >= 32'(BURST_LEN));
  assign w_lastBurst = (r_burst == BCNT_W'(NBURST - 1));

  // A burst is only requested once a full burst of data sits in the FIFO,
  // so the W phase can only stall on FIFO hiccups, never on a short frame tail.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_addr    <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_awlen   <= '0;
      r_wrErr   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (init_txn) begin
      r_state   <= ST_IDLE;
      r_slot    <= '0;
      r_addr    <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_awlen   <= '0;
      r_wrErr   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (frame_store && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_store) begin
            r_slot  <= frame_type;
            r_addr  <= BASE_ADDR + (ADDR_W'(frame_type) * SLOT_BYTES);
            r_burst <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_countOk) begin
            r_awlen <= 8'(BURST_LEN - 1);
            r_state <= ST_AW;
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            r_beat  <= '0;
            r_state <= ST_W;
          end
        end
        ST_W: begin
          if (w_wbeat) begin
            if (w_lastBeat) begin
              r_state <= ST_B;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != AXI_RESP_OKAY) begin
              r_wrErr <= 1'b1;
            end
            r_addr  <= r_addr + BURST_BYTES;
            r_burst <= r_burst + BCNT_W'(1);
            r_state <= w_lastBurst ? ST_DONE : ST_WAIT;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axi_awaddr    = r_addr;
  assign m_axi_awlen     = r_awlen;
  assign m_axi_awsize    = AXI_SIZE_4B;
  assign m_axi_awburst   = AXI_BURST_INCR;
  assign m_axi_awvalid   = (r_state == ST_AW);
  assign m_axi_wdata     = (r_state == ST_W) ? fifo_rddata : 32'h0;
  assign m_axi_wstrb     = 4'hF;
  assign m_axi_wlast     = (r_state == ST_W) && w_lastBeat;
  assign m_axi_wvalid    = w_wvalid;
  assign fifo_rden       = w_wbeat;
  assign m_axi_bready    = (r_state == ST_B);
  assign busy            = (r_state != ST_IDLE);
  assign frame_done      = (r_state == ST_DONE);
  assign frame_done_type = (r_state == ST_DONE) ? r_slot : 2'b00;
  assign wr_err          = r_wrErr;
  assign frame_overrun   = r_overrun;

endmodule
